// File: rtl/async_fifo_pkg.sv
// Gray/binary conversion helpers shared by both FIFO pointer handlers.
// Functions work on a 32-bit carrier; callers zero-extend and truncate.
package async_fifo_pkg;

    localparam int GRAY_MAX_W = 32;

    typedef logic [GRAY_MAX_W-1:0] gvec_t;

    function automatic gvec_t bin2gray(input gvec_t b);
        return b ^ (b >> 1);
    endfunction

    // Zero upper bits pass through as zero, so any narrower width is exact
    function automatic gvec_t gray2bin(input gvec_t g);
        gvec_t b;
        b[GRAY_MAX_W-1] = g[GRAY_MAX_W-1];
        for (int i = GRAY_MAX_W - 2; i >= 0; i--) begin
            b[i] = b[i+1] ^ g[i];
        end
        return b;
    endfunction

endpackage

// File: rtl/rptr_empty_ctrl_if.sv
// Read-side pointer/flag bundle between the FIFO read port and its handler.
// master drives the request and foreign pointer; slave is the handler.
interface rptr_empty_ctrl_if #(
    parameter int ADDR_W = 4
);
    logic              r_en;
    logic [ADDR_W:0]   g_wptr;
    logic [ADDR_W-1:0] raddr;
    logic [ADDR_W:0]   g_rptr;
    logic              empty;
    logic              almost_empty;
    logic [ADDR_W:0]   rd_count;
    logic              underflow;

    modport master (
        output r_en, g_wptr,
        input  raddr, g_rptr, empty, almost_empty, rd_count, underflow
    );

    modport slave (
        input  r_en, g_wptr,
        output raddr, g_rptr, empty, almost_empty, rd_count, underflow
    );
endinterface

// File: rtl/gray_sync.sv
// Multi-flop synchroniser for a Gray-coded pointer crossing clock domains.
// The input feeds the first flop directly with no logic in between.
module gray_sync #(
    parameter int WIDTH  = 5,
    parameter int STAGES = 2
) (
    input  logic             rclk,
    input  logic             rrst_n,
    input  logic [WIDTH-1:0] i_d,
    output logic [WIDTH-1:0] o_q
);
    logic [WIDTH-1:0] r_sync [STAGES];

    always_ff @(posedge rclk or negedge rrst_n) begin
        if (!rrst_n) begin
            for (int i = 0; i < STAGES; i++) begin
                r_sync[i] <= '0;
            end
        end else begin
            r_sync[0] <= i_d;
            for (int i = 1; i < STAGES; i++) begin
                r_sync[i] <= r_sync[i-1];
            end
        end
    end

    assign o_q = r_sync[STAGES-1];
endmodule

// File: rtl/rptr_empty_ctrl.sv
// Async FIFO read-pointer handler: read pointer, empty/almost-empty, level.
// Optional sticky underflow flag enabled by macro RPTR_UNDERFLOW_FLAG_EN.
module rptr_empty_ctrl
    import async_fifo_pkg::*;
#(
    parameter int ADDR_W      = 4,
    parameter int SYNC_STAGES = 2,
    parameter int AE_THRESH   = 2
) (
    input  logic           rclk,
    input  logic           rrst_n,
    rptr_empty_ctrl_if.slave bus
);
    localparam int PW = ADDR_W + 1;

    logic [PW-1:0] r_b_rptr;
    logic [PW-1:0] r_g_rptr;
    logic [PW-1:0] r_rd_count;
    logic          r_empty;
    logic          r_almost_empty;

    logic          w_rd;
    logic [PW-1:0] w_g_wptr_s;
    logic [PW-1:0] w_b_wptr_s;
    logic [PW-1:0] w_b_rptr_next;
    logic [PW-1:0] w_g_rptr_next;
    logic [PW-1:0] w_count_next;

    gray_sync #(
        .WIDTH  (PW),
        .STAGES (SYNC_STAGES)
    ) u_wptr_sync (
        .rclk   (rclk),
        .rrst_n (rrst_n),
        .i_d    (bus.g_wptr),
        .o_q    (w_g_wptr_s)
    );

    // Next-state values feed the flags so the last read empties at once
    always_comb begin
        w_rd          = bus.r_en && !r_empty;
        w_b_rptr_next = r_b_rptr + PW'(w_rd);
        w_g_rptr_next = PW'(bin2gray(gvec_t'(w_b_rptr_next)));
        w_b_wptr_s    = PW'(gray2bin(gvec_t'(w_g_wptr_s)));
        w_count_next  = w_b_wptr_s - w_b_rptr_next;
    end

    always_ff @(posedge rclk or negedge rrst_n) begin
        if (!rrst_n) begin
            r_b_rptr       <= '0;
            r_g_rptr       <= '0;
            r_rd_count     <= '0;
            r_empty        <= 1'b1;
            r_almost_empty <= 1'b1;
        end else begin
            r_b_rptr       <= w_b_rptr_next;
            r_g_rptr       <= w_g_rptr_next;
            r_rd_count     <= w_count_next;
            r_empty        <= (w_g_rptr_next == w_g_wptr_s);
            r_almost_empty <= (w_count_next <= PW'(AE_THRESH));
        end
    end

`ifdef RPTR_UNDERFLOW_FLAG_EN
    logic r_underflow;

    always_ff @(posedge rclk or negedge rrst_n) begin
        if (!rrst_n) begin
            r_underflow <= 1'b0;
        end else if (bus.r_en && r_empty) begin
            r_underflow <= 1'b1;
        end
    end

    assign bus.underflow = r_underflow;
`else
    assign bus.underflow = 1'b0;
`endif

    assign bus.raddr        = r_b_rptr[ADDR_W-1:0];
    assign bus.g_rptr       = r_g_rptr;
    assign bus.empty        = r_empty;
    assign bus.almost_empty = r_almost_empty;
    assign bus.rd_count     = r_rd_count;
endmodule

// File: doc/rptr_empty_ctrl.md
RPTR_EMPTY_CTRL -- requirements
Module: rptr_empty_ctrl

Interface
REQ-001 The block SHALL have parameter ADDR_W, default 4, FIFO address width; depth = 2**ADDR_W.
REQ-002 The block SHALL have parameter SYNC_STAGES, default 2, range 2..4, number of write-pointer synchroniser flops.
REQ-003 The block SHALL have parameter AE_THRESH, default 2, range 0..2**ADDR_W-1, almost-empty level in entries.
REQ-004 The block SHALL have port rclk, input, 1, read clock, the only clock; all flops are rising-edge.
REQ-005 The block SHALL have port rrst_n, input, 1, reset; it is asynchronous and active-low.
REQ-006 The block SHALL have port r_en, input, 1, read request.
REQ-007 The block SHALL have port g_wptr, input, ADDR_W+1, Gray write pointer, asynchronous to rclk.
REQ-008 The block SHALL have port raddr, output, ADDR_W, RAM read address = b_rptr[ADDR_W-1:0].
REQ-009 The block SHALL have port g_rptr, output, ADDR_W+1, registered Gray read pointer for the write domain.
REQ-010 The block SHALL have port empty, output, 1, registered empty flag.
REQ-011 The block SHALL have port almost_empty, output, 1, registered almost-empty flag.
REQ-012 The block SHALL have port rd_count, output, ADDR_W+1, registered fill level seen by the read side.
REQ-013 The block SHALL have port underflow, output, 1, sticky underflow flag.

Function
REQ-014 The binary read pointer b_rptr, ADDR_W+1 bits, SHALL advance by 1 on a rising rclk edge iff r_en && !empty; it wraps modulo 2**(ADDR_W+1).
REQ-015 g_rptr SHALL be registered from bin2gray(b_rptr_next) on the same edge, so raddr and g_rptr change in the same cycle.
REQ-016 g_wptr SHALL pass through SYNC_STAGES flops to form g_wptr_s; no logic SHALL sit between g_wptr and the first flop.
REQ-017 empty SHALL be registered as (bin2gray(b_rptr_next) == g_wptr_s).
REQ-018 rd_count SHALL be registered as (gray2bin(g_wptr_s) - b_rptr_next) mod 2**(ADDR_W+1); it is 0 when empty and at most 2**ADDR_W.
REQ-019 almost_empty SHALL be registered as (rd_count_next <= AE_THRESH), and is therefore always 1 while empty is 1.
REQ-020 A write-pointer change SHALL deassert empty exactly SYNC_STAGES+1 rclk edges after it is presented stably at g_wptr.
REQ-021 A read of the last entry SHALL assert empty on the same edge that advances b_rptr, so there is zero read-to-empty latency.
REQ-022 r_en while empty SHALL NOT move b_rptr, g_rptr, raddr or rd_count.
REQ-023 A read while empty SHALL drive the underflow behaviour defined in REQ-028.
REQ-024 Wrap of b_rptr from 2**(ADDR_W+1)-1 to 0 SHALL change exactly one g_rptr bit.

Reset
REQ-025 While rrst_n=0, the block SHALL hold b_rptr, g_rptr, raddr, rd_count and the synchroniser flops at 0.
REQ-026 While rrst_n=0, empty=1, almost_empty=1 and underflow=0.
REQ-027 Reset asserted mid-operation SHALL take effect immediately without rclk; deassertion is assumed synchronised externally to rclk.

Configuration
REQ-028 With macro RPTR_UNDERFLOW_FLAG_EN defined, underflow SHALL set on the edge after any cycle with r_en && empty and hold until reset.
REQ-029 Without RPTR_UNDERFLOW_FLAG_EN, underflow SHALL be tied to 0 with no flop, and the port SHALL remain present.

Structure
REQ-030 Package async_fifo_pkg SHALL hold the bin2gray and gray2bin functions, both parametrised by width via a width-generic implementation.
REQ-031 The synchroniser SHALL be sub-module gray_sync with parameters WIDTH and STAGES, clock rclk and reset rrst_n; it is reused by the write-side handler.

Verification (ADDR_W=4, SYNC_STAGES=2, AE_THRESH=2)
REQ-032 Reset: rrst_n=0 mid-traffic -> outputs 0 immediately; empty=1, almost_empty=1, underflow=0.
REQ-033 Fill: g_wptr 00000->00001 held -> empty=0 on 3rd rclk edge, rd_count=1, almost_empty=1.
REQ-034 Drain: g_wptr_s=gray(5), r_en=1 for 5 cycles -> raddr 0..4, rd_count 5,4,3,2,1,0; almost_empty rises when rd_count=2; empty rises on the 5th read edge.
REQ-035 Underflow: empty=1, r_en=1 one cycle -> b_rptr unchanged; underflow=1 and sticky with macro, 0 without.
REQ-036 Wrap: 40 write/read pairs -> b_rptr wraps 31->0, g_rptr 10000->00000, every g_rptr change has Hamming distance 1.
REQ-037 Full level: g_wptr_s=gray(16), b_rptr=0 -> rd_count=16, almost_empty=0, empty=0.
